ws2812_driver: RTL and testbench
================================

# ws2812_driver

Synthesizable serial encoder that sits directly upstream of the first `led` instance in a WS2812 chain. It accepts 24-bit pixel words over a valid/ready handshake and drives `o_serial` with the WS2812 one-wire waveform, MSB first. It inserts the reset/latch (RET) low period at the end of each frame. It replaces the behavioural bit-bang tasks as the source of `i_serial` for the chain.

## Interface
- `T0H_CYC`, default 20: high time of a '0' bit, in clocks (400 ns at 50 MHz).
- `T1H_CYC`, default 40: high time of a '1' bit, in clocks (800 ns).
- `BIT_CYC`, default 62: total bit period, in clocks (1240 ns).
- `RET_CYC`, default 2600: latch low period, in clocks (52 µs). Must be ≥ 1.
- Legal parameter set: 0 < `T0H_CYC` < `T1H_CYC` < `BIT_CYC`.
- `i_clk`  input  1: the single clock.
- `i_rst`  input  1: reset, asynchronous, active-high.
- `i_data`  input  24: pixel word. Bit 23 is transmitted first.
- `i_valid`  input  1: `i_data`/`i_last` valid.
- `i_last`  input  1: the pixel is the final pixel of the frame.
- `o_ready`  output  1: the holding register is empty; a pixel is accepted on `i_valid & o_ready`.
- `o_serial`  output  1: WS2812 data line (registered).
- `o_busy`  output  1: the block is not in IDLE.
- `o_underrun`  output  1: one-cycle pulse when a frame is terminated because no pixel was available.

## Operation
- Datapath:
  - Holding register (24-bit data, last flag, full flag) feeds the shift register (24-bit) plus a `cur_last` flag.
  - 5-bit bit counter.
  - Cycle counter sized to `clog2(max(BIT_CYC, RET_CYC)+1)`.
- `o_ready` = ~hold_full. On accept, hold is loaded and hold_full is set.
- States: IDLE, HIGH, LOW, RET.
- IDLE:
  - `o_serial` = 0.
  - If hold_full: move hold into the shift register, clear hold_full, set bit count to 23, go to HIGH.
- HIGH:
  - `o_serial` = 1 for Th cycles, where Th = `T1H_CYC` if shift[23] else `T0H_CYC`.
  - Then go to LOW.
- LOW:
  - `o_serial` = 0 for `BIT_CYC` − Th cycles.
  - At the end, if bit count > 0: shift left, decrement the count, go to HIGH.
  - At the end of bit 0, checked in this order:
    - If `cur_last`: go to RET.
    - Else if hold_full: load the next pixel, go to HIGH. This is gapless; the next high starts on the cycle after the last low cycle.
    - Else: pulse `o_underrun`, go to RET.
- RET:
  - `o_serial` = 0 for `RET_CYC` cycles, then go to IDLE.
  - Pixels may be accepted during RET. They start transmission after RET.
- Simultaneous accept and pop in the same cycle: hold holds the new pixel, and hold_full stays 1.
- Reset, asynchronous and at any point including mid-bit or mid-RET:
  - State = IDLE, `o_serial` = 0, hold_full = 0 (so `o_ready` = 1), `o_busy` = 0, `o_underrun` = 0.
  - The pixel in flight is discarded.
  - No RET is generated on reset exit. The downstream `led` must see ≥ RET low before the first frame; the line is low while in reset.

## Timing
- Accept in IDLE at cycle N: hold_full is set at N+1, and `o_serial` rises at N+2.
- Each bit is exactly `BIT_CYC` clocks, rising edge to rising edge, including across pixel boundaries when hold is refilled in time.
- Frame of P pixels, from the first rising edge to IDLE: P·24·`BIT_CYC` + `RET_CYC` (+1 for the state update).
- Deadline for the next pixel to be gapless: the accept must occur no later than the final LOW cycle of bit 0 of the current pixel.
- `o_busy` is high from the HIGH entry through the last RET cycle.
- `o_underrun` is high for exactly the cycle of the LOW→RET transition.

## Test plan
- Two-pixel frame: `24'hFF00FF`, then `24'h00FF00` with `i_last`, driven into two chained `led` instances.
  - After RET, `data_out[0]` must equal `24'hFF00FF` and `data_out[1]` must equal `24'h00FF00`.
  - High widths must be 40 cycles for 1-bits and 20 cycles for 0-bits. Every period must be 62 cycles.
  - After the frame, the line must stay low for 2600 cycles.
- Back-to-back pixels with `i_valid` held high:
  - `o_ready` must drop after the first accept and re-rise when the shift register loads.
  - The 24→25th bit rising-edge interval must be exactly 62 cycles.
- Underrun: send one pixel `24'hA5A5A5` without `i_last` and no follow-up.
  - `o_underrun` must pulse once at the end of bit 0, RET must follow, and the LED must latch `24'hA5A5A5`.
- Assert `i_rst` in the middle of a HIGH phase of bit 10.
  - `o_serial` must go to 0 immediately (asynchronously), `o_ready` = 1, `o_busy` = 0.
  - A fresh frame after ≥ RET of idle time must transfer correctly.
- Accept during RET: offer a pixel 100 cycles into RET.
  - It must be accepted at once, and its first rising edge must occur only after the full 2600-cycle RET.
- Parameter corner: `T0H_CYC`=1, `T1H_CYC`=2, `BIT_CYC`=3, `RET_CYC`=1.
  - Waveform widths must match the parameters exactly, and `24'h800001` must encode correctly.

Source files
------------

// File: rtl/ws2812_driver.sv
// rtl/ws2812_driver.sv - WS2812 one-wire serial encoder with a one-pixel holding register
// Encodes 24-bit pixels MSB first and appends the latch low period at frame end.
module ws2812_driver #(
    parameter int T0H_CYC = 20,
    parameter int T1H_CYC = 40,
    parameter int BIT_CYC = 62,
    parameter int RET_CYC = 2600
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_data,
    input  logic        i_valid,
    input  logic        i_last,
    output logic        o_ready,
    output logic        o_serial,
    output logic        o_busy,
    output logic        o_underrun
);
    localparam int MAX_CYC = (BIT_CYC > RET_CYC) ? BIT_CYC : RET_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, RET} state_t;

    state_t        state, state_nxt;
    logic [23:0]   hold_data;
    logic          hold_last;
    logic          hold_full;
    logic [23:0]   shift;
    logic          cur_last;
    logic [4:0]    bit_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] high_end;
    logic [CW-1:0] low_end;
    logic          accept;
    logic          pop;
    logic          shift_bit;
    logic          cnt_clr;

    assign accept   = i_valid && !hold_full;
    assign o_ready  = !hold_full;
    assign o_busy   = (state != IDLE);

    // Terminal counts of the current bit's high and low phases, chosen by its value.
    assign high_end = shift[23] ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
    assign low_end  = shift[23] ? CW'(BIT_CYC - T1H_CYC - 1) : CW'(BIT_CYC - T0H_CYC - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        shift_bit  = 1'b0;
        cnt_clr    = 1'b0;
        o_underrun = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    pop       = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (cyc_cnt == high_end) begin
                    cnt_clr   = 1'b1;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (cyc_cnt == low_end) begin
                    cnt_clr = 1'b1;
                    if (bit_cnt != 5'd0) begin
                        shift_bit = 1'b1;
                        state_nxt = HIGH;
                    end else if (cur_last) begin
                        state_nxt = RET;
                    end else if (hold_full) begin
                        pop       = 1'b1;
                        state_nxt = HIGH;
                    end else begin
                        o_underrun = 1'b1;
                        state_nxt  = RET;
                    end
                end
            end
            RET: begin
                if (cyc_cnt == CW'(RET_CYC - 1)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_serial  <= 1'b0;
            cyc_cnt   <= '0;
            bit_cnt   <= 5'd0;
            shift     <= 24'd0;
            cur_last  <= 1'b0;
            hold_data <= 24'd0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
        end else begin
            // Registered line: high exactly while the FSM occupies HIGH.
            o_serial <= (state_nxt == HIGH);

            if (cnt_clr || state == IDLE) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end

            if (pop) begin
                shift    <= hold_data;
                cur_last <= hold_last;
                bit_cnt  <= 5'd23;
            end else if (shift_bit) begin
                shift   <= {shift[22:0], 1'b0};
                bit_cnt <= bit_cnt - 5'd1;
            end

            if (accept) begin
                hold_data <= i_data;
                hold_last <= i_last;
                hold_full <= 1'b1;
            end else if (pop) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ws2812_driver.sv
// tb/tb_ws2812_driver.sv - scoreboard bench for ws2812_driver (default and minimal timing)
// A line decoder per DUT rebuilds pixels from high widths and checks them against pushed words.
module tb_ws2812_driver;
    localparam int T0H[2]  = '{20, 1};
    localparam int T1H[2]  = '{40, 2};
    localparam int BITC[2] = '{62, 3};
    localparam int RETC[2] = '{2600, 1};

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][23:0] data;
    logic [1:0]       valid;
    logic [1:0]       last;
    logic [1:0]       rdy;
    logic [1:0]       ser;
    logic [1:0]       busy;
    logic [1:0]       und;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [23:0] q0[$];
    logic [23:0] q1[$];

    int          rise_cnt[2]  = '{0, 0};
    int          word_cnt[2]  = '{0, 0};
    int          under_cnt[2] = '{0, 0};
    int          under_cyc[2] = '{0, 0};
    int          last_rise[2] = '{0, 0};
    int          last_fall[2] = '{0, 0};
    int          hi[2]        = '{0, 0};
    int          nb[2]        = '{0, 0};
    logic        prev[2]      = '{1'b0, 1'b0};
    logic        have_rise[2] = '{1'b0, 1'b0};
    logic [23:0] word[2]      = '{24'd0, 24'd0};
    logic [23:0] expw;
    int          qsz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_driver dut_a (
        .i_clk(clk), .i_rst(rst), .i_data(data[0]), .i_valid(valid[0]), .i_last(last[0]),
        .o_ready(rdy[0]), .o_serial(ser[0]), .o_busy(busy[0]), .o_underrun(und[0])
    );

    ws2812_driver #(.T0H_CYC(1), .T1H_CYC(2), .BIT_CYC(3), .RET_CYC(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data(data[1]), .i_valid(valid[1]), .i_last(last[1]),
        .o_ready(rdy[1]), .o_serial(ser[1]), .o_busy(busy[1]), .o_underrun(und[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                prev[i] = 1'b0; hi[i] = 0; nb[i] = 0; have_rise[i] = 1'b0;
            end else begin
                if (und[i]) begin
                    under_cnt[i]++;
                    under_cyc[i] = cyc;
                end
                if (ser[i]) begin
                    if (!prev[i]) begin
                        if (have_rise[i] && (cyc - last_rise[i]) < BITC[i] + RETC[i])
                            chk($sformatf("bit_period_dut%0d", i), cyc - last_rise[i], BITC[i]);
                        last_rise[i] = cyc;
                        have_rise[i] = 1'b1;
                        rise_cnt[i]++;
                    end
                    hi[i]++;
                end else if (prev[i]) begin
                    chk($sformatf("high_width_dut%0d_w%0d", i, hi[i]),
                        32'((hi[i] == T0H[i]) || (hi[i] == T1H[i])), 32'd1);
                    word[i] = {word[i][22:0], (hi[i] == T1H[i])};
                    nb[i]++;
                    hi[i] = 0;
                    last_fall[i] = cyc;
                    if (nb[i] == 24) begin
                        nb[i] = 0;
                        word_cnt[i]++;
                        qsz = (i == 0) ? q0.size() : q1.size();
                        chk($sformatf("sb_pending_dut%0d", i), 32'(qsz > 0), 32'd1);
                        if (qsz > 0) begin
                            expw = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("pixel_dut%0d", i), 32'(word[i]), 32'(expw));
                        end
                    end
                end
                prev[i] = ser[i];
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves valid high so consecutive calls present a continuous stream.
    task automatic send(input int i, input logic [23:0] d, input logic l, input logic push);
        int n = 0;
        while (!rdy[i] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(rdy[i]), 32'd1);
        data[i]  = d;
        last[i]  = l;
        valid[i] = 1'b1;
        if (push) begin
            if (i == 0) q0.push_back(d);
            else q1.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int i);
        valid[i] = 1'b0;
        last[i]  = 1'b0;
    endtask

    task automatic wait_words(input int i, input int target);
        int n = 0;
        while (word_cnt[i] < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("word_timeout", 32'(word_cnt[i] >= target), 32'd1);
    endtask

    task automatic wait_rise(input int i, input int target);
        int n = 0;
        while (rise_cnt[i] < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("rise_timeout", 32'(rise_cnt[i] >= target), 32'd1);
    endtask

    int base, r, lr, u;

    initial begin
        rst = 1'b1; data = '0; valid = 2'b00; last = 2'b00;
        wait_n(3);
        chk("rst_ready", 32'(rdy), 32'h3);
        chk("rst_serial", 32'(ser), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_underrun", 32'(und), 32'h0);
        rst = 1'b0;
        wait_n(2);

        // Two-pixel frame, with first-accept latency and post-frame latch window.
        base = word_cnt[0];
        send(0, 24'hFF00FF, 1'b0, 1'b1);
        chk("accept_ready_low", 32'(rdy[0]), 32'd0);
        chk("accept_busy_low", 32'(busy[0]), 32'd0);
        @(negedge clk);
        chk("load_ready_high", 32'(rdy[0]), 32'd1);
        chk("load_serial_high", 32'(ser[0]), 32'd1);
        chk("load_busy_high", 32'(busy[0]), 32'd1);
        send(0, 24'h00FF00, 1'b1, 1'b1);
        idle(0);
        wait_words(0, base + 2);
        r = rise_cnt[0];
        wait_n(2630);
        chk("ret_busy", 32'(busy[0]), 32'd1);
        chk("ret_serial_low", 32'(ser[0]), 32'd0);
        wait_n(20);
        chk("ret_done_idle", 32'(busy[0]), 32'd0);
        chk("ret_no_rise", 32'(rise_cnt[0]), 32'(r));

        // Back-to-back stream with valid held high.
        base = word_cnt[0];
        send(0, 24'hC3C3C3, 1'b0, 1'b1);
        send(0, 24'h3C3C3C, 1'b0, 1'b1);
        send(0, 24'h0F0F0F, 1'b1, 1'b1);
        idle(0);
        wait_words(0, base + 3);
        wait_n(2700);

        // Underrun: non-last pixel with nothing behind it.
        base = word_cnt[0];
        u = under_cnt[0];
        send(0, 24'hA5A5A5, 1'b0, 1'b1);
        idle(0);
        wait_words(0, base + 1);
        wait_n(40);
        chk("underrun_once", 32'(under_cnt[0]), 32'(u + 1));
        chk("underrun_at_bit0_end", 32'(under_cyc[0] - last_fall[0]), 32'(BITC[0] - T1H[0] - 1));
        chk("underrun_in_ret", 32'(busy[0]), 32'd1);
        wait_n(2700);
        chk("underrun_single", 32'(under_cnt[0]), 32'(u + 1));
        chk("underrun_idle", 32'(busy[0]), 32'd0);

        // Asynchronous reset in the high phase of bit 10, with a pixel waiting in hold.
        r = rise_cnt[0];
        send(0, 24'hFFFFFF, 1'b0, 1'b0);
        send(0, 24'h123456, 1'b1, 1'b0);
        idle(0);
        wait_rise(0, r + 14);
        wait_n(10);
        chk("pre_reset_serial", 32'(ser[0]), 32'd1);
        chk("pre_reset_hold_full", 32'(rdy[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_serial", 32'(ser[0]), 32'd0);
        chk("async_ready", 32'(rdy[0]), 32'd1);
        chk("async_busy", 32'(busy[0]), 32'd0);
        chk("async_underrun", 32'(und[0]), 32'd0);
        wait_n(2);
        rst = 1'b0;
        wait_n(2700);
        base = word_cnt[0];
        send(0, 24'h5A5AC3, 1'b1, 1'b1);
        idle(0);
        wait_words(0, base + 1);
        wait_n(2700);

        // Pixel offered 100 cycles into the latch period.
        base = word_cnt[0];
        send(0, 24'h123456, 1'b1, 1'b1);
        idle(0);
        wait_words(0, base + 1);
        wait_n(142);
        chk("in_ret_ready", 32'(rdy[0]), 32'd1);
        chk("in_ret_busy", 32'(busy[0]), 32'd1);
        r = rise_cnt[0];
        lr = last_rise[0];
        send(0, 24'hABCDEF, 1'b1, 1'b1);
        idle(0);
        chk("in_ret_accepted", 32'(rdy[0]), 32'd0);
        chk("in_ret_serial_low", 32'(ser[0]), 32'd0);
        wait_rise(0, r + 1);
        chk("ret_full_length", 32'(last_rise[0] - lr), 32'(BITC[0] + RETC[0] + 1));
        wait_words(0, base + 2);
        wait_n(2700);

        // Minimal-timing instance.
        base = word_cnt[1];
        send(1, 24'h800001, 1'b1, 1'b1);
        idle(1);
        wait_words(1, base + 1);
        wait_n(10);
        send(1, 24'h00FF0F, 1'b0, 1'b1);
        send(1, 24'hF0F0F0, 1'b1, 1'b1);
        idle(1);
        wait_words(1, base + 3);
        wait_n(10);
        chk("corner_idle", 32'(busy[1]), 32'd0);
        chk("corner_no_underrun", 32'(under_cnt[1]), 32'd0);

        chk("sb_drained_a", 32'(q0.size()), 32'd0);
        chk("sb_drained_b", 32'(q1.size()), 32'd0);
        chk("underrun_total", 32'(under_cnt[0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
